core_alu_issue_queue: RTL and testbench

- Operand-collecting issue queue that drives core_detachable_alu.
- Accepts decoded ALU ops whose source operands may still be pending, and captures those operands from the writeback broadcast bus.
- Issues one ready entry per cycle into the ALU's r0/r1/pc/grand_op/op inputs, then registers the ALU result with its destination tag for writeback, using a valid/ready handshake.

---
 rtl/core_alu_iq_pkg.sv | 21 ++
 rtl/core_alu_iq_entry.sv | 56 +++++
 rtl/core_alu_issue_queue.sv | 141 ++++++++++++++
 tb/tb_core_alu_issue_queue.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_alu_iq_pkg.sv
// Shared types for the ALU issue queue: the per-entry record and the
// physical tag width it is built around.
package core_alu_iq_pkg;

    localparam int IQ_TAG_W = 6;

    typedef struct packed {
        logic                valid;
        logic [31:0]         r0;
        logic [31:0]         r1;
        logic                r0_rdy;
        logic                r1_rdy;
        logic [IQ_TAG_W-1:0] r0_tag;
        logic [IQ_TAG_W-1:0] r1_tag;
        logic [31:0]         pc;
        logic [1:0]          grand_op;
        logic [1:0]          op;
        logic [IQ_TAG_W-1:0] dst_tag;
    } iq_entry_t;

endpackage

// File: rtl/core_alu_iq_entry.sv
// One issue-queue slot: holds a decoded ALU op and snoops the writeback bus
// for pending operands, including capture on the enqueue cycle itself.
module core_alu_iq_entry
    import core_alu_iq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                enq_i,
    input  logic                issue_i,
    input  iq_entry_t           enq_entry_i,
    input  logic                wb_valid_i,
    input  logic [IQ_TAG_W-1:0] wb_tag_i,
    input  logic [31:0]         wb_data_i,
    output iq_entry_t           entry_o,
    output logic                ready_to_issue_o
);

    iq_entry_t entry_q, entry_d;

    always_comb begin
        entry_d = entry_q;
        if (flush_i) begin
            entry_d.valid = 1'b0;
        end else begin
            if (enq_i) begin
                entry_d = enq_entry_i;
            end else if (issue_i) begin
                entry_d.valid = 1'b0;
            end
            // Wakeup runs on the post-enqueue view so a same-cycle broadcast is not lost.
            if (entry_d.valid && wb_valid_i) begin
                if (!entry_d.r0_rdy && (entry_d.r0_tag == wb_tag_i)) begin
                    entry_d.r0     = wb_data_i;
                    entry_d.r0_rdy = 1'b1;
                end
                if (!entry_d.r1_rdy && (entry_d.r1_tag == wb_tag_i)) begin
                    entry_d.r1     = wb_data_i;
                    entry_d.r1_rdy = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o          = entry_q;
    assign ready_to_issue_o = entry_q.valid && entry_q.r0_rdy && entry_q.r1_rdy;

endmodule

// File: rtl/core_alu_issue_queue.sv
// Operand-collecting issue queue in front of the detachable ALU: lowest free
// slot on enqueue, lowest ready slot on issue, one registered result stage.
module core_alu_issue_queue
    import core_alu_iq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = IQ_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_r0_i,
    input  logic [31:0]      in_r1_i,
    input  logic             in_r0_rdy_i,
    input  logic             in_r1_rdy_i,
    input  logic [TAG_W-1:0] in_r0_tag_i,
    input  logic [TAG_W-1:0] in_r1_tag_i,
    input  logic [31:0]      in_pc_i,
    input  logic [1:0]       in_grand_op_i,
    input  logic [1:0]       in_op_i,
    input  logic [TAG_W-1:0] in_dst_tag_i,
    input  logic             wb_valid_i,
    input  logic [TAG_W-1:0] wb_tag_i,
    input  logic [31:0]      wb_data_i,
    output logic [31:0]      alu_r0_o,
    output logic [31:0]      alu_r1_o,
    output logic [31:0]      alu_pc_o,
    output logic [1:0]       alu_grand_op_o,
    output logic [1:0]       alu_op_o,
    input  logic [31:0]      alu_res_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [TAG_W-1:0] out_tag_o,
    output logic [31:0]      out_data_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    iq_entry_t              entries   [DEPTH];
    iq_entry_t              enq_entry;
    iq_entry_t              sel_entry;
    logic [DEPTH-1:0]       valid_vec, rdy_vec, enq_vec, issue_vec;
    logic [IDX_W-1:0]       free_idx, iss_idx;
    logic                   iss_any, issue_fire, enq_fire;
    logic                   out_valid_q, out_valid_d;
    logic [TAG_W-1:0]       out_tag_q, out_tag_d;
    logic [31:0]            out_data_q, out_data_d;

    always_comb begin
        enq_entry          = '0;
        enq_entry.valid    = 1'b1;
        enq_entry.r0       = in_r0_i;
        enq_entry.r1       = in_r1_i;
        enq_entry.r0_rdy   = in_r0_rdy_i;
        enq_entry.r1_rdy   = in_r1_rdy_i;
        enq_entry.r0_tag   = in_r0_tag_i;
        enq_entry.r1_tag   = in_r1_tag_i;
        enq_entry.pc       = in_pc_i;
        enq_entry.grand_op = in_grand_op_i;
        enq_entry.op       = in_op_i;
        enq_entry.dst_tag  = in_dst_tag_i;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            core_alu_iq_entry u_entry (
                .clk              (clk),
                .rst_n            (rst_n),
                .flush_i          (flush_i),
                .enq_i            (enq_vec[gi]),
                .issue_i          (issue_vec[gi]),
                .enq_entry_i      (enq_entry),
                .wb_valid_i       (wb_valid_i),
                .wb_tag_i         (wb_tag_i),
                .wb_data_i        (wb_data_i),
                .entry_o          (entries[gi]),
                .ready_to_issue_o (rdy_vec[gi])
            );
            assign valid_vec[gi] = entries[gi].valid;
            assign enq_vec[gi]   = enq_fire && (free_idx == IDX_W'(gi));
            assign issue_vec[gi] = issue_fire && (iss_idx == IDX_W'(gi));
        end
    endgenerate

    // Scanning downward leaves the lowest qualifying index as the winner.
    always_comb begin
        free_idx = '0;
        iss_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_vec[i]) free_idx = i[IDX_W-1:0];
            if (rdy_vec[i])    iss_idx  = i[IDX_W-1:0];
        end
    end

    assign iss_any    = |rdy_vec;
    assign issue_fire = iss_any && (!out_valid_q || out_ready_i);
    assign in_ready_o = ~&valid_vec;
    assign enq_fire   = in_valid_i && in_ready_o;

    assign sel_entry      = entries[iss_idx];
    assign alu_r0_o       = sel_entry.r0;
    assign alu_r1_o       = sel_entry.r1;
    assign alu_pc_o       = sel_entry.pc;
    assign alu_grand_op_o = sel_entry.grand_op;
    assign alu_op_o       = sel_entry.op;

    always_comb begin
        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        out_data_d  = out_data_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (issue_fire) begin
            out_valid_d = 1'b1;
            out_tag_d   = sel_entry.dst_tag;
            out_data_d  = alu_res_i;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_tag_o   = out_tag_q;
    assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_core_alu_issue_queue.sv
// Directed and random stimulus for the ALU issue queue, checked every cycle
// against a slot-array reference model and a stand-in ALU.
module tb_core_alu_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush_i, in_valid_i, in_ready_o;
    logic [31:0]      in_r0_i, in_r1_i, in_pc_i;
    logic             in_r0_rdy_i, in_r1_rdy_i;
    logic [TAG_W-1:0] in_r0_tag_i, in_r1_tag_i, in_dst_tag_i;
    logic [1:0]       in_grand_op_i, in_op_i;
    logic             wb_valid_i;
    logic [TAG_W-1:0] wb_tag_i;
    logic [31:0]      wb_data_i;
    logic [31:0]      alu_r0_o, alu_r1_o, alu_pc_o, alu_res_i;
    logic [1:0]       alu_grand_op_o, alu_op_o;
    logic             out_valid_o, out_ready_i;
    logic [TAG_W-1:0] out_tag_o;
    logic [31:0]      out_data_o;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(logic [1:0] g, logic [1:0] op,
                                          logic [31:0] a, logic [31:0] b, logic [31:0] pc);
        case (g)
            2'd0:    case (op) 2'd0: return a + b; 2'd1: return a - b;
                               2'd2: return a & b; default: return a | b; endcase
            2'd1:    case (op) 2'd0: return a ^ b; 2'd1: return a << b[4:0];
                               2'd2: return a >> b[4:0]; default: return {31'd0, a < b}; endcase
            2'd2:    return pc + a;
            default: return pc + 32'd4 + {30'd0, op};
        endcase
    endfunction

    assign alu_res_i = alu_f(alu_grand_op_o, alu_op_o, alu_r0_o, alu_r1_o, alu_pc_o);

    core_alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_r0_i(in_r0_i), .in_r1_i(in_r1_i),
        .in_r0_rdy_i(in_r0_rdy_i), .in_r1_rdy_i(in_r1_rdy_i),
        .in_r0_tag_i(in_r0_tag_i), .in_r1_tag_i(in_r1_tag_i),
        .in_pc_i(in_pc_i), .in_grand_op_i(in_grand_op_i), .in_op_i(in_op_i),
        .in_dst_tag_i(in_dst_tag_i),
        .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i), .wb_data_i(wb_data_i),
        .alu_r0_o(alu_r0_o), .alu_r1_o(alu_r1_o), .alu_pc_o(alu_pc_o),
        .alu_grand_op_o(alu_grand_op_o), .alu_op_o(alu_op_o), .alu_res_i(alu_res_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_tag_o(out_tag_o), .out_data_o(out_data_o)
    );

    // Reference model: one record per slot plus the result register.
    typedef struct {
        bit               v;
        logic [31:0]      r0, r1, pc;
        bit               r0r, r1r;
        logic [TAG_W-1:0] t0, t1, dst;
        logic [1:0]       g, op;
    } ment_t;

    ment_t            m [DEPTH];
    bit               mo_v;
    logic [TAG_W-1:0] mo_t;
    logic [31:0]      mo_d;
    int               n_total = 0;
    int               n_pass  = 0;
    int               n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = '{v: 0, r0: 0, r1: 0, pc: 0, r0r: 0, r1r: 0, t0: 0, t1: 0, dst: 0, g: 0, op: 0};
        end
        mo_v = 0; mo_t = '0; mo_d = '0;
    endtask

    function automatic int m_sel();
        for (int i = 0; i < DEPTH; i++) if (m[i].v && m[i].r0r && m[i].r1r) return i;
        return -1;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < DEPTH; i++) if (!m[i].v) return i;
        return -1;
    endfunction

    task automatic idle();
        flush_i = 0; in_valid_i = 0; wb_valid_i = 0; out_ready_i = 1;
        in_r0_i = 0; in_r1_i = 0; in_r0_rdy_i = 0; in_r1_rdy_i = 0;
        in_r0_tag_i = 0; in_r1_tag_i = 0; in_pc_i = 0;
        in_grand_op_i = 0; in_op_i = 0; in_dst_tag_i = 0;
        wb_tag_i = 0; wb_data_i = 0;
    endtask

    task automatic set_in(input logic [31:0] r0, input bit r0r, input int t0,
                          input logic [31:0] r1, input bit r1r, input int t1,
                          input logic [31:0] pc, input int g, input int op, input int dst);
        in_valid_i = 1;
        in_r0_i = r0; in_r0_rdy_i = r0r; in_r0_tag_i = TAG_W'(t0);
        in_r1_i = r1; in_r1_rdy_i = r1r; in_r1_tag_i = TAG_W'(t1);
        in_pc_i = pc; in_grand_op_i = 2'(g); in_op_i = 2'(op); in_dst_tag_i = TAG_W'(dst);
    endtask

    task automatic set_wb(input int tag, input logic [31:0] data);
        wb_valid_i = 1; wb_tag_i = TAG_W'(tag); wb_data_i = data;
    endtask

    // One clock: compare outputs mid-cycle, advance the model, cross the edge.
    task automatic cyc();
        int s, e, fi;
        bit full;
        @(negedge clk);
        s = m_sel();
        e = (s < 0) ? 0 : s;
        fi = m_free();
        full = (fi < 0);
        chk("in_ready", {31'd0, in_ready_o}, {31'd0, !full});
        chk("out_valid", {31'd0, out_valid_o}, {31'd0, mo_v});
        chk("out_tag", {26'd0, out_tag_o}, {26'd0, mo_t});
        chk("out_data", out_data_o, mo_d);
        chk("alu_r0", alu_r0_o, m[e].r0);
        chk("alu_r1", alu_r1_o, m[e].r1);
        chk("alu_pc", alu_pc_o, m[e].pc);
        chk("alu_gop_op", {28'd0, alu_grand_op_o, alu_op_o}, {28'd0, m[e].g, m[e].op});
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) m[i].v = 0;
            mo_v = 0;
        end else begin
            if (s >= 0 && (!mo_v || out_ready_i)) begin
                mo_v = 1;
                mo_d = alu_f(m[s].g, m[s].op, m[s].r0, m[s].r1, m[s].pc);
                mo_t = m[s].dst;
                m[s].v = 0;
            end else if (out_ready_i) begin
                mo_v = 0;
            end
            if (in_valid_i && !full) begin
                m[fi] = '{v: 1, r0: in_r0_i, r1: in_r1_i, pc: in_pc_i,
                          r0r: in_r0_rdy_i, r1r: in_r1_rdy_i,
                          t0: in_r0_tag_i, t1: in_r1_tag_i, dst: in_dst_tag_i,
                          g: in_grand_op_i, op: in_op_i};
            end
            if (wb_valid_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (m[i].v && !m[i].r0r && m[i].t0 == wb_tag_i) begin m[i].r0 = wb_data_i; m[i].r0r = 1; end
                    if (m[i].v && !m[i].r1r && m[i].t1 == wb_tag_i) begin m[i].r1 = wb_data_i; m[i].r1r = 1; end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        chk("rst_out_data", out_data_o, 32'd0);
        chk("rst_alu_r0", alu_r0_o, 32'd0);
        rst_n = 1;
        cyc();

        // 1: both operands ready -> ALU sees them next cycle, result the one after
        set_in(5, 1, 0, 7, 1, 0, 32'h100, 0, 0, 3); cyc();
        idle();
        chk("t1_alu_r0", alu_r0_o, 32'd5);
        chk("t1_alu_r1", alu_r1_o, 32'd7);
        cyc();
        chk("t1_out_valid", {31'd0, out_valid_o}, 32'd1);
        chk("t1_out_tag", {26'd0, out_tag_o}, 32'd3);
        chk("t1_out_data", out_data_o, 32'd12);
        cyc();

        // 2: r1 pending on tag 9, woken two cycles later
        set_in(1, 1, 0, 0, 0, 9, 32'h200, 0, 0, 5); cyc();
        idle(); cyc(); cyc();
        set_wb(9, 32'h10); cyc();
        idle();
        chk("t2_alu_r1", alu_r1_o, 32'h10);
        cyc();
        chk("t2_out_data", out_data_o, 32'h11);
        cyc();

        // 3: enqueue-cycle bypass of tag 4
        set_in(0, 0, 4, 2, 1, 0, 32'h300, 0, 0, 6);
        set_wb(4, 32'hFF); cyc();
        idle();
        chk("t3_alu_r0", alu_r0_o, 32'hFF);
        cyc();
        chk("t3_out_data", out_data_o, 32'h101);
        cyc();

        // 4: fill with pending ops, wake only slot 2
        for (int i = 0; i < DEPTH; i++) begin
            set_in(0, 0, 20 + i, i, 1, 0, 32'h400, 0, 0, 40 + i); cyc();
        end
        idle();
        chk("t4_full", {31'd0, in_ready_o}, 32'd0);
        set_wb(22, 32'h40); cyc();
        idle();
        chk("t4_alu_r0", alu_r0_o, 32'h40);
        chk("t4_full_during_issue", {31'd0, in_ready_o}, 32'd0);
        cyc();
        chk("t4_ready_after", {31'd0, in_ready_o}, 32'd1);
        chk("t4_out_tag", {26'd0, out_tag_o}, 32'd42);
        for (int t = 20; t < 24; t++) begin set_wb(t, 32'(t)); cyc(); end
        idle(); cyc(); cyc(); cyc();

        // 5: back-pressure holds the first result and defers the second issue
        out_ready_i = 0;
        set_in(1, 1, 0, 2, 1, 0, 0, 0, 0, 10); cyc();
        set_in(3, 1, 0, 4, 1, 0, 0, 0, 0, 11); out_ready_i = 0; cyc();
        idle(); out_ready_i = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t5_hold_tag", {26'd0, out_tag_o}, 32'd10);
            chk("t5_hold_data", out_data_o, 32'd3);
        end
        out_ready_i = 1; cyc();
        chk("t5_second_tag", {26'd0, out_tag_o}, 32'd11);
        chk("t5_second_data", out_data_o, 32'd7);
        cyc();

        // 6: flush beats a simultaneous enqueue
        out_ready_i = 0;
        set_in(1, 1, 0, 1, 1, 0, 0, 0, 0, 12); cyc();
        set_in(0, 0, 30, 0, 0, 30, 0, 0, 0, 13); out_ready_i = 0; cyc();
        set_in(0, 0, 31, 0, 0, 31, 0, 0, 0, 14); out_ready_i = 0; cyc();
        set_in(9, 1, 0, 9, 1, 0, 0, 0, 0, 15); out_ready_i = 0; flush_i = 1; cyc();
        idle();
        chk("t6_out_valid", {31'd0, out_valid_o}, 32'd0);
        cyc();
        chk("t6_not_enqueued", {31'd0, out_valid_o}, 32'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(0, 2) != 0)
                set_in($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                       $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                       $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 63));
            if ($urandom_range(0, 1) != 0) set_wb($urandom_range(0, 7), $urandom);
            out_ready_i = ($urandom_range(0, 3) != 0);
            flush_i     = ($urandom_range(0, 31) == 0);
            cyc();
        end

        // Asynchronous reset in the middle of a cycle with work outstanding
        idle(); out_ready_i = 0;
        set_in(1, 1, 0, 1, 1, 0, 0, 0, 0, 7); cyc();
        set_in(0, 0, 5, 0, 0, 5, 0, 0, 0, 8); out_ready_i = 0; cyc();
        idle();
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("async_rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        chk("async_rst_out_tag", {26'd0, out_tag_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
